fetch_unit: RTL

- Instruction-fetch stage sitting directly upstream of the decode/execute core.
- Owns the program counter and issues reads to the instruction memory (1-cycle read latency).
- Buffers returned words with their PC in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts branch redirects from execute: flushes the FIFO, discards in-flight reads and restarts fetch at the target.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/fetch_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg: shared widths and the buffered fetch entry type           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fetch_pkg;

    localparam int c_num_instr  = 10;
    localparam int c_reg_width  = 32;
    localparam int c_fifo_depth = 4;

    // PC must hold NUM_INSTR itself so the run-off value is representable.
    function automatic int pc_width(input int num_instr);
        return $clog2(num_instr + 1);
    endfunction

    localparam int c_pc_w = $clog2(c_num_instr + 1);

    typedef struct packed {
        logic [c_pc_w-1:0]      pc;
        logic [c_reg_width-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo: single-clock FIFO with flush, count and full/empty flags  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [AW:0]      o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage is cleared on reset so the head reads zero until first push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit: PC, credit-based imem issue, instruction buffer, redirect |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int NUM_INSTR  = c_num_instr,
    parameter int REG_WIDTH  = c_reg_width,
    parameter int FIFO_DEPTH = c_fifo_depth,
    parameter int PC_W       = pc_width(NUM_INSTR)
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [PC_W-1:0]      imem_addr,
    input  logic [REG_WIDTH-1:0] imem_rdata,
    input  logic                 redirect_valid,
    input  logic [PC_W-1:0]      redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_WIDTH-1:0] out_instr,
    output logic [PC_W-1:0]      out_pc,
    output logic                 halted
);

    localparam int c_cw = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic [REG_WIDTH-1:0] instr;
    } entry_t;

    logic [PC_W-1:0] r_fetch_pc;
    logic [PC_W-1:0] r_tag;
    logic            r_inflight;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [c_cw-1:0] w_count;
    logic [c_cw-1:0] w_used;
    entry_t          w_wr_entry;
    entry_t          w_rd_entry;

    // Credits cover the in-flight read so a response always has a free slot.
    assign w_used  = w_count + {{(c_cw-1){1'b0}}, r_inflight};
    assign w_issue = !rst && !redirect_valid
                   && (r_fetch_pc < PC_W'(NUM_INSTR))
                   && (w_used < c_cw'(FIFO_DEPTH));

    assign imem_req  = w_issue;
    assign imem_addr = r_fetch_pc;

    // A redirect kills the response arriving in the same cycle.
    assign w_push           = r_inflight && !redirect_valid;
    assign w_wr_entry.pc    = r_tag;
    assign w_wr_entry.instr = imem_rdata;

    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;
    assign out_instr = w_rd_entry.instr;
    assign out_pc    = w_rd_entry.pc;
    assign halted    = (r_fetch_pc >= PC_W'(NUM_INSTR)) && w_empty && !r_inflight;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= '0;
            r_tag      <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) r_tag <= r_fetch_pc;
            if (redirect_valid)
                r_fetch_pc <= redirect_pc;
            else if (w_issue)
                r_fetch_pc <= r_fetch_pc + 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wr_entry),
        .o_rdata (w_rd_entry),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule
`default_nettype wire
